sorted_ram_writer: RTL and testbench

Fills a 32-entry × 8-bit table one value at a time and keeps it in ascending order at all times. Each insertion walks down from the top occupied slot, moving larger entries up by one slot per cycle until it finds the correct position. The block exposes a synchronous read port with one-cycle latency, so the binary-search controller reads it exactly as it reads the ROM. In the lab top level it sits alongside the searcher, loaded from SW[7:0] with a KEY-driven start.

---
 rtl/sorted_ram_writer.sv | 121 ++++++++++++
 tb/tb_sorted_ram_writer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sorted_ram_writer.sv
// Sorted 32x8 table: each insert walks down from the top occupied slot,
// shifting larger entries up one slot per cycle. Registered read port.
module sorted_ram_writer #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy,
  output logic              done,
  output logic              rejected
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic signed [DATA_W-1:0]  r_unused_sign;
  logic [DATA_W-1:0]         r_mem [DEPTH];
  logic [DATA_W-1:0]         r_val;
  logic [DATA_W-1:0]         r_rd_data;
  logic [ADDR_W:0]           r_hole;
  logic [ADDR_W:0]           r_count;
  logic                      r_rejected;
  logic [ADDR_W-1:0]         w_slot;
  logic [ADDR_W-1:0]         w_below_idx;
  logic [DATA_W-1:0]         w_below;
  logic                      w_place;
  logic                      w_full;

  assign w_slot      = r_hole[ADDR_W-1:0];
  assign w_below_idx = w_slot - ADDR_W'(1);
  assign w_below     = r_mem[w_below_idx];
  // Stop on <= so equal values land above existing ones (stable order).
  assign w_place     = (r_hole == '0) || (w_below <= r_val);
  assign w_full      = (r_count == (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!clear && start) w_next = w_full ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (w_place) w_next = S_DONE;
      end
      S_DONE: begin
        if (!start) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '1;
      r_val      <= '0;
      r_hole     <= '0;
      r_count    <= '0;
      r_rejected <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '1;
            r_count <= '0;
          end else if (start) begin
            if (!w_full) begin
              r_val      <= data_in;
              r_hole     <= r_count;
              r_rejected <= 1'b0;
            end else begin
              r_rejected <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (w_place) begin
            r_mem[w_slot] <= r_val;
            r_count       <= r_count + (ADDR_W+1)'(1);
          end else begin
            r_mem[w_slot] <= w_below;
            r_hole        <= r_hole - (ADDR_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_data <= '1;
    else       r_rd_data <= r_mem[rd_addr];
  end

  assign r_unused_sign = '0;
  assign rd_data  = r_rd_data;
  assign count    = r_count;
  assign full     = w_full;
  assign busy     = (r_state == S_SHIFT);
  assign done     = (r_state == S_DONE);
  assign rejected = r_rejected;

endmodule

// File: tb/tb_sorted_ram_writer.sv
// Bench for sorted_ram_writer: directed scenarios plus random inserts,
// checked against a sorted-queue reference model.
module tb_sorted_ram_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       clear;
  logic [7:0] data_in;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [5:0] count;
  logic       full;
  logic       busy;
  logic       done;
  logic       rejected;

  int n_checks = 0;
  int n_pass   = 0;
  int q[$];

  sorted_ram_writer #(.DEPTH(32), .ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .data_in(data_in), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .full(full), .busy(busy), .done(done),
    .rejected(rejected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int mref(input int a);
    return (a < q.size()) ? q[a] : 255;
  endfunction

  task automatic read_all();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_addr = 5'(i);
      @(posedge clk);
      #1;
      check($sformatf("rd[%0d]", i), rd_data, mref(i));
    end
    check("count", count, q.size());
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    check("clear_count", count, 0);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic do_insert(input int v, input bit hold);
    int n, p, exp_edges, edges;
    bit rej;
    n = q.size();
    p = 0;
    foreach (q[i]) if (q[i] <= v) p++;
    rej = (n == 32);
    exp_edges = rej ? 1 : (n - p) + 2;
    @(negedge clk);
    data_in = 8'(v);
    start = 1'b1;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) check("busy_e1", busy, !rej);
    end while (!done && edges < 40);
    check($sformatf("latency(%0d)", v), edges, exp_edges);
    if (!rej) q.insert(p, v);
    check("rejected", rejected, rej);
    check("ins_count", count, q.size());
    check("full", full, q.size() == 32);
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      check("hold_done", done, 1);
      check("hold_count", count, q.size());
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("back_idle", done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; data_in = '0; rd_addr = '0;
    #1;
    check("rst_rd", rd_data, 255);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rej", rejected, 0);
    check("rst_full", full, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    read_all();

    // Single append into empty table
    do_insert(40, 1'b0);
    read_all();

    do_clear();
    do_insert(50, 1'b0);
    do_insert(10, 1'b0);
    do_insert(30, 1'b1);
    read_all();

    do_clear();
    do_insert(30, 1'b0);
    do_insert(30, 1'b0);
    do_insert(20, 1'b0);
    do_insert(255, 1'b0);
    read_all();

    // Fill with descending values, then a refused request
    do_clear();
    for (int i = 0; i < 32; i++) do_insert(200 - 6 * i, 1'b0);
    do_insert(7, 1'b1);
    read_all();
    check("full_flag", full, 1);

    // Reset aborts a walk in progress
    do_clear();
    for (int i = 0; i < 20; i++) do_insert(int'($urandom_range(1, 254)), 1'b0);
    @(negedge clk);
    data_in = 8'd0;
    start = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    q.delete();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_count", count, 0);
    check("abort_rd", rd_data, 255);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    read_all();

    // clear wins over start in idle
    do_insert(99, 1'b0);
    @(negedge clk);
    clear = 1'b1; start = 1'b1; data_in = 8'd5;
    @(posedge clk);
    #1;
    q.delete();
    check("cs_busy", busy, 0);
    check("cs_done", done, 0);
    check("cs_count", count, 0);
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    read_all();

    // Random mix of inserts, clears and spot reads
    for (int k = 0; k < 80; k++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        do_clear();
      end else if (r < 14) begin
        do_insert(int'($urandom_range(0, 255)), 1'b0);
      end else begin
        int a;
        a = int'($urandom_range(0, 31));
        @(negedge clk);
        rd_addr = 5'(a);
        @(posedge clk);
        #1;
        check($sformatf("rnd_rd[%0d]", a), rd_data, mref(a));
      end
    end
    read_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
